// File: rtl/io_out_collector.sv
// Collects output words from four cores into a shared FIFO, tagging each word
// with its source core; cores are served round-robin with sticky overrun flags.
module io_out_collector #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic signed [WIDTH-1:0]  io_out0,
  input  logic signed [WIDTH-1:0]  io_out1,
  input  logic signed [WIDTH-1:0]  io_out2,
  input  logic signed [WIDTH-1:0]  io_out3,
  input  logic [1:0]               out_en0,
  input  logic [1:0]               out_en1,
  input  logic [1:0]               out_en2,
  input  logic [1:0]               out_en3,
  output logic signed [WIDTH-1:0]  dout,
  output logic [1:0]               dout_src,
  output logic                     dout_valid,
  input  logic                     dout_ready,
  output logic [$clog2(DEPTH):0]   count,
  output logic [3:0]               ovf
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned NC = 4;

  typedef struct packed {
    logic [1:0]       src;
    logic [WIDTH-1:0] data;
  } entry_t;

  logic [WIDTH-1:0] din [NC];
  logic [NC-1:0]    cap_en;
  logic [WIDTH-1:0] cap_q [NC];
  logic [NC-1:0]    pend_q;
  logic [1:0]       rr_q;
  entry_t           mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  logic             gnt_vld;
  logic [1:0]       gnt_idx;
  logic [1:0]       idx;
  logic [NC-1:0]    gnt;
  logic             push;
  logic             pop;

  assign din[0] = io_out0;
  assign din[1] = io_out1;
  assign din[2] = io_out2;
  assign din[3] = io_out3;

  assign cap_en = {out_en3 == 2'b01, out_en2 == 2'b01,
                   out_en1 == 2'b01, out_en0 == 2'b01};

  // Round-robin search from rr_q; iterate downward so the nearest pending core wins.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = 2'd0;
    idx     = 2'd0;
    if (count != CW'(DEPTH)) begin
      for (int i = NC - 1; i >= 0; i--) begin
        idx = rr_q + 2'(i);
        if (pend_q[idx]) begin
          gnt_vld = 1'b1;
          gnt_idx = idx;
        end
      end
    end
  end

  assign gnt        = gnt_vld ? (NC'(1) << gnt_idx) : '0;
  assign push       = gnt_vld;
  assign dout_valid = (count != '0);
  assign pop        = dout_valid && dout_ready;

  // Head is gated so an empty FIFO presents zeros.
  always_comb begin
    dout     = '0;
    dout_src = 2'd0;
    if (dout_valid) begin
      dout     = signed'(mem[rd_ptr].data);
      dout_src = mem[rd_ptr].src;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < NC; k++) cap_q[k] <= '0;
      pend_q <= '0;
      ovf    <= '0;
      rr_q   <= 2'd0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      for (int k = 0; k < NC; k++) begin
        if (cap_en[k]) cap_q[k] <= din[k];
      end
      // A capture on the granting edge keeps the core pending with the new word.
      pend_q <= cap_en | (pend_q & ~gnt);
      ovf    <= ovf | (cap_en & pend_q & ~gnt);
      if (gnt_vld) rr_q   <= gnt_idx + 2'd1;
      if (push)    wr_ptr <= wr_ptr + AW'(1);
      if (pop)     rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Storage carries no reset; validity is tracked by count.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{src: gnt_idx, data: cap_q[gnt_idx]};
  end

endmodule

// File: tb/tb_io_out_collector.sv
// Directed bench for io_out_collector: stimulus queues expected words, a
// negedge monitor pops and compares every word the consumer accepts.
module tb_io_out_collector;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned DEPTH = 8;

  logic                    clk = 1'b0;
  logic                    rst;
  logic signed [WIDTH-1:0] io_out0, io_out1, io_out2, io_out3;
  logic [1:0]              out_en0, out_en1, out_en2, out_en3;
  logic signed [WIDTH-1:0] dout;
  logic [1:0]              dout_src;
  logic                    dout_valid;
  logic                    dout_ready;
  logic [3:0]              count;
  logic [3:0]              ovf;

  typedef struct packed {
    logic [1:0]  src;
    logic [31:0] data;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad   = 0;

  io_out_collector #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst),
    .io_out0(io_out0), .io_out1(io_out1), .io_out2(io_out2), .io_out3(io_out3),
    .out_en0(out_en0), .out_en1(out_en1), .out_en2(out_en2), .out_en3(out_en3),
    .dout(dout), .dout_src(dout_src), .dout_valid(dout_valid),
    .dout_ready(dout_ready), .count(count), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle_all();
    out_en0 = 2'b00; out_en1 = 2'b00; out_en2 = 2'b00; out_en3 = 2'b00;
  endtask

  task automatic strobe(input int k, input logic [31:0] v);
    case (k)
      0: begin out_en0 = 2'b01; io_out0 = v; end
      1: begin out_en1 = 2'b01; io_out1 = v; end
      2: begin out_en2 = 2'b01; io_out2 = v; end
      default: begin out_en3 = 2'b01; io_out3 = v; end
    endcase
  endtask

  task automatic expect_word(input int k, input logic [31:0] v);
    sb.push_back('{src: 2'(k), data: v});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    idle_all();
  endtask

  task automatic do_reset();
    rst = 1'b0;
    idle_all();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 40; i++) begin
      if (!dout_valid) break;
      tick();
    end
    check(name, 32'(dout_valid), 32'd0);
  endtask

  // Monitor: every accepted head word must match the next expected entry.
  always @(negedge clk) begin
    if (rst && dout_valid && dout_ready) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL unexpected_word: got src=%0d data=%0h expected none", dout_src, dout);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (dout_src !== e.src || dout !== signed'(e.data)) begin
          bad++;
          $display("FAIL word: got src=%0d data=%0h expected src=%0d data=%0h",
                   dout_src, dout, e.src, e.data);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst        = 1'b0;
    dout_ready = 1'b0;
    io_out0 = '0; io_out1 = '0; io_out2 = '0; io_out3 = '0;
    idle_all();
    #2;
    check("rst_dout", dout, 32'd0);
    check("rst_src", 32'(dout_src), 32'd0);
    check("rst_valid", 32'(dout_valid), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;

    // Single word from core 2, visible two edges after the strobe
    dout_ready = 1'b1;
    strobe(2, -32'sd5);
    expect_word(2, -32'sd5);
    tick();
    check("single_valid_after_capture", 32'(dout_valid), 32'd0);
    tick();
    check("single_valid_after_grant", 32'(dout_valid), 32'd1);
    check("single_src", 32'(dout_src), 32'd2);
    check("single_count", 32'(count), 32'd1);
    tick();
    check("single_valid_after_pop", 32'(dout_valid), 32'd0);

    // Round robin from rr=0, twice to show rr returns to 0
    do_reset();
    dout_ready = 1'b1;
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < 4; k++) begin
        strobe(k, 32'(10 * (r + 1) + k));
        expect_word(k, 32'(10 * (r + 1) + k));
      end
      tick();
      for (int k = 0; k < 4; k++) begin
        tick();
        check("rr_valid", 32'(dout_valid), 32'd1);
        check("rr_src", 32'(dout_src), 32'(k));
      end
      tick();
      check("rr_drained", 32'(dout_valid), 32'd0);
    end

    // Fill the FIFO with one strobe per cycle, then overrun core 1 while full
    do_reset();
    dout_ready = 1'b0;
    for (int c = 0; c < 9; c++) begin
      strobe(c % 4, 32'(1000 + c));
      if (c < 8) expect_word(c % 4, 32'(1000 + c));
      tick();
    end
    check("full_count", 32'(count), 32'd8);
    strobe(1, 32'd100);
    tick();
    check("full_hold_count", 32'(count), 32'd8);
    check("full_no_ovf", 32'(ovf), 32'd0);
    strobe(1, 32'd200);
    tick();
    check("overrun_ovf", 32'(ovf), 32'b0010);
    check("overrun_count", 32'(count), 32'd8);
    expect_word(0, 32'd1008);
    expect_word(1, 32'd200);
    dout_ready = 1'b1;
    tick();
    check("full_pop_no_push", 32'(count), 32'd7);
    drain("full_drain");
    check("full_sb_empty", 32'(sb.size()), 32'd0);
    check("full_ovf_sticky", 32'(ovf), 32'b0010);

    // Capture on the granting edge keeps both words, no overrun
    strobe(3, 32'd51);
    expect_word(3, 32'd51);
    tick();
    strobe(3, -32'sd7);
    expect_word(3, -32'sd7);
    tick();
    tick();
    drain("cog_drain");
    check("cog_ovf3", 32'(ovf[3]), 32'd0);
    check("cog_sb_empty", 32'(sb.size()), 32'd0);

    // Five words buffered, then an asynchronous reset between edges
    dout_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      strobe(0, 32'(500 + i));
      tick();
    end
    tick();
    check("mid_count_before", 32'(count), 32'd5);
    #2;
    rst = 1'b0;
    #1;
    check("mid_rst_count", 32'(count), 32'd0);
    check("mid_rst_valid", 32'(dout_valid), 32'd0);
    check("mid_rst_ovf", 32'(ovf), 32'd0);
    check("mid_rst_dout", dout, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    dout_ready = 1'b1;
    repeat (3) tick();
    check("mid_discarded", 32'(dout_valid), 32'd0);
    check("final_sb_empty", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/io_out_collector.md
IO_OUT_COLLECTOR -- requirements
Module: io_out_collector

Interface
REQ-001 Parameters SHALL be: DEPTH, 8, FIFO entries (power of two, >=2); WIDTH, 32, data width.
REQ-002 Port clk SHALL be input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 Port rst SHALL be input, 1 bit, asynchronous active-low reset (rst=0 resets immediately).
REQ-004 Ports io_out0..io_out3 SHALL be inputs, signed WIDTH bits each, per-core output data.
REQ-005 Ports out_en0..out_en3 SHALL be inputs, 2 bits each, per-core output strobe; value 2'b01 = write, any other value = idle.
REQ-006 Port dout SHALL be output, signed WIDTH bits, FIFO head data.
REQ-007 Port dout_src SHALL be output, 2 bits, core index (0-3) that produced dout.
REQ-008 Port dout_valid SHALL be output, 1 bit, FIFO non-empty.
REQ-009 Port dout_ready SHALL be input, 1 bit, consumer accepts head this cycle.
REQ-010 Port count SHALL be output, log2(DEPTH)+1 bits, FIFO occupancy.
REQ-011 Port ovf SHALL be output, 4 bits, sticky per-core overrun flags.

Function
REQ-012 Each core k SHALL own a capture register cap_k (WIDTH bits) and pending bit pend_k.
REQ-013 Capture: when out_enk==2'b01 at a rising edge, cap_k SHALL load io_outk and pend_k SHALL be set.
REQ-014 Overrun: capture while pend_k=1 and core k not granted that cycle SHALL overwrite cap_k and set ovf[k]; ovf[k] clears only on reset.
REQ-015 Arbitration: each cycle, if count<DEPTH, the arbiter SHALL grant one pending core, searching round-robin from pointer rr (2 bits) upward mod 4.
REQ-016 After a grant to core k, rr SHALL become (k+1) mod 4; with no grant rr SHALL hold.
REQ-017 Grant to core k SHALL push {k, cap_k} into the FIFO and clear pend_k, unless a capture for core k occurs the same edge, in which case cap_k takes the new value, pend_k stays 1, and ovf[k] is not set.
REQ-018 Full: when count==DEPTH no grant SHALL occur (a simultaneous pop does not enable a push); pending entries hold.
REQ-019 Pop: when dout_valid=1 and dout_ready=1, the head SHALL be removed at the rising edge; dout_ready with dout_valid=0 SHALL have no effect.
REQ-020 Simultaneous push and pop SHALL leave count unchanged and preserve order.
REQ-021 dout/dout_src SHALL show the FIFO head combinationally from registered storage; dout_valid SHALL equal (count!=0).
REQ-022 Read/write pointers SHALL be log2(DEPTH) bits and wrap from DEPTH-1 to 0.
REQ-023 Latency: capture at edge N -> grant at edge N+1 (if not full and won arbitration) -> dout_valid=1 after edge N+1, i.e. 2 edges min from strobe to visible output.
REQ-024 Data order SHALL be FIFO-preserved per grant order; no word SHALL be duplicated or dropped except by overrun (REQ-014).

Reset
REQ-025 rst=0 SHALL asynchronously clear pend_k, cap_k, ovf, rr, FIFO pointers and count; outputs SHALL read dout=0, dout_src=0, dout_valid=0, count=0, ovf=0.
REQ-026 Reset asserted mid-operation SHALL discard all buffered and pending data; no push or pop SHALL occur while rst=0.
REQ-027 After rst rises, the first edge SHALL already accept captures.

Verification
REQ-028 Single word: out_en2=01, io_out2=-5 for one cycle, dout_ready=1 -> dout_valid=1 two edges later with dout=-5, dout_src=2, then dout_valid=0.
REQ-029 Round robin: all four cores strobe same cycle (values 10,11,12,13), rr=0 -> outputs in order src 0,1,2,3 on consecutive cycles, rr ends at 0.
REQ-030 Full: dout_ready=0, cores strobe repeatedly -> count saturates at 8, no further grants, pending holds; raise dout_ready -> draining resumes in order, nothing lost except flagged overruns.
REQ-031 Overrun: core 1 strobes 100 then 200 on consecutive cycles while FIFO full -> ovf[1]=1, only 200 emerges from core 1.
REQ-032 Capture-on-grant: core 3 strobes two consecutive cycles with FIFO empty -> both words emerge, ovf[3]=0.
REQ-033 Reset mid-stream: FIFO count=5, drive rst=0 -> count=0, dout_valid=0, ovf=0 immediately without a clock edge.
